// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan path.
// Contents: arbiter FSM state encoding, blank/off constants, and the hex glyph
// table as a helper function (active-low {g,f,e,d,c,b,a}).
package ssd_pkg;

  typedef enum logic [1:0] {
    StEntry = 2'd0,
    StWait  = 2'd1,
    StShow  = 2'd2
  } ssd_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  function automatic logic [6:0] hex_glyph(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = GLYPH_0;
      4'h1:    seg = GLYPH_1;
      4'h2:    seg = GLYPH_2;
      4'h3:    seg = GLYPH_3;
      4'h4:    seg = GLYPH_4;
      4'h5:    seg = GLYPH_5;
      4'h6:    seg = GLYPH_6;
      4'h7:    seg = GLYPH_7;
      4'h8:    seg = GLYPH_8;
      4'h9:    seg = GLYPH_9;
      4'hA:    seg = GLYPH_A;
      4'hB:    seg = GLYPH_B;
      4'hC:    seg = GLYPH_C;
      4'hD:    seg = GLYPH_D;
      4'hE:    seg = GLYPH_E;
      default: seg = GLYPH_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Ports:
//   hex_i  4-bit nibble 0-F
//   seg_o  segments, active-low {g,f,e,d,c,b,a}
module hex_to_seg
  import ssd_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = hex_glyph(hex_i);
  end

endmodule

// File: rtl/ssd_display_arbiter.sv
// Four-digit seven-segment scan controller shared between the code-entry
// datapath (live hex nibbles) and the lock FSM (raw segment messages shown for
// MSG_FRAMES full scan frames).
// Ports:
//   clk, rst             scan clock, asynchronous active-high reset
//   ent_val/data/mask    entry source: valid, four nibbles (digit 0 rightmost), per-digit enable
//   msg_req, msg_seg     one-cycle message request and its 28-bit active-low pattern
//   msg_busy, msg_done   message pending/showing, one-cycle pulse on return to entry
//   owner                0 = entry, 1 = message
//   AN, seven_out        registered active-low anodes and segments
// Optional: define SSD_MSG_BLINK_EN to blank the message on frames with frame count bit 2 set.
module ssd_display_arbiter
  import ssd_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 5000,
  parameter int unsigned MSG_FRAMES = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ent_val,
  input  logic [15:0] ent_data,
  input  logic [3:0]  ent_mask,
  input  logic        msg_req,
  input  logic [27:0] msg_seg,
  output logic        msg_busy,
  output logic        msg_done,
  output logic        owner,
  output logic [3:0]  AN,
  output logic [6:0]  seven_out
);

  localparam int unsigned TickW  = $clog2(SCAN_DIV);
  localparam int unsigned FrameW = 16;
  localparam logic [TickW-1:0]  TickLast  = TickW'(SCAN_DIV - 1);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(MSG_FRAMES - 1);

  logic [TickW-1:0]  tick_q;
  logic [1:0]        idx_q;
  ssd_state_e        state_q, state_d;
  logic [FrameW-1:0] frame_q, frame_d;
  logic [27:0]       pat_q, pat_d;
  logic              done_q, done_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic       tick_wrap;
  logic       frame_bnd;
  logic [3:0] ent_nib;
  logic [6:0] ent_glyph;
  logic [6:0] msg_slice;

  assign tick_wrap = (tick_q == TickLast);
  assign frame_bnd = tick_wrap && (idx_q == 2'd3);

  // Scan timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= '0;
      idx_q  <= 2'd0;
    end else if (tick_wrap) begin
      tick_q <= '0;
      idx_q  <= idx_q + 2'd1;
    end else begin
      tick_q <= tick_q + TickW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEntry;
      frame_q <= '0;
      pat_q   <= {4{SEG_BLANK}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      pat_q   <= pat_d;
      done_q  <= done_d;
    end
  end

  // FSM next state; a request always re-latches the pattern
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    pat_d   = msg_req ? msg_seg : pat_q;
    done_d  = 1'b0;
    case (state_q)
      StEntry: begin
        if (msg_req) state_d = StWait;
      end
      StWait: begin
        // Ownership starts at a frame boundary so the message begins on digit 0
        if (frame_bnd) begin
          state_d = StShow;
          frame_d = '0;
        end
      end
      StShow: begin
        // A retrigger wins over the final boundary: no done, count restarts
        if (msg_req) begin
          frame_d = '0;
        end else if (frame_bnd) begin
          if (frame_q == FrameLast) begin
            state_d = StEntry;
            done_d  = 1'b1;
          end else begin
            frame_d = frame_q + FrameW'(1);
          end
        end
      end
      default: state_d = StEntry;
    endcase
  end

  // FSM outputs
  always_comb begin
    owner    = (state_q == StShow);
    msg_busy = (state_q != StEntry);
    msg_done = done_q;
  end

  always_comb begin
    unique case (idx_q)
      2'd0: begin ent_nib = ent_data[3:0];   msg_slice = pat_q[6:0];   end
      2'd1: begin ent_nib = ent_data[7:4];   msg_slice = pat_q[13:7];  end
      2'd2: begin ent_nib = ent_data[11:8];  msg_slice = pat_q[20:14]; end
      2'd3: begin ent_nib = ent_data[15:12]; msg_slice = pat_q[27:21]; end
      default: begin ent_nib = 4'h0; msg_slice = SEG_BLANK; end
    endcase
  end

  hex_to_seg u_hex_to_seg (
    .hex_i (ent_nib),
    .seg_o (ent_glyph)
  );

  always_comb begin
    an_d  = ~(4'b0001 << idx_q);
    seg_d = ent_glyph;
    if (owner) begin
      seg_d = msg_slice;
`ifdef SSD_MSG_BLINK_EN
      if (frame_q[2]) an_d = AN_OFF;
`else
`endif
    end else if (!ent_val || !ent_mask[idx_q]) begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign AN        = an_q;
  assign seven_out = seg_q;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Self-checking bench for ssd_display_arbiter (SCAN_DIV=4, MSG_FRAMES=3).
// The reference model works in absolute cycle numbers since reset release:
// frame boundaries fall on cycles c with c % 16 == 15, and a message owns the
// display between a start and an end boundary derived from request times.
module tb_ssd_display_arbiter;

  localparam int unsigned ScanDiv   = 4;
  localparam int unsigned MsgFrames = 3;
  localparam int FrameLen = 4 * ScanDiv;
  localparam logic [6:0] Glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                                        7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21,
                                        7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ent_val = 1'b0;
  logic [15:0] ent_data = '0;
  logic [3:0]  ent_mask = '0;
  logic        msg_req = 1'b0;
  logic [27:0] msg_seg = '0;
  logic        msg_busy, msg_done, owner;
  logic [3:0]  AN;
  logic [6:0]  seven_out;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned done_seen = 0;

  // Reference model state
  int          c = 0;
  bit          m_busy = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_done = 1'b0;
  int          m_start = 0;
  int          m_end = 0;
  logic [27:0] m_pat = '0;

  ssd_display_arbiter #(
    .SCAN_DIV   (ScanDiv),
    .MSG_FRAMES (MsgFrames)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ent_val   (ent_val),
    .ent_data  (ent_data),
    .ent_mask  (ent_mask),
    .msg_req   (msg_req),
    .msg_seg   (msg_seg),
    .msg_busy  (msg_busy),
    .msg_done  (msg_done),
    .owner     (owner),
    .AN        (AN),
    .seven_out (seven_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", tag, got, exp, c, $time);
    end
  endtask

  // First frame boundary strictly after cycle cc
  function automatic int next_bnd(input int cc);
    int b;
    b = (cc / FrameLen) * FrameLen + FrameLen - 1;
    if (b == cc) b += FrameLen;
    return b;
  endfunction

  function automatic logic [31:0] pick_pattern();
    return 32'($urandom);
  endfunction

  // One clock: called just after a posedge; drives at the negedge, checks at posedge+1
  task automatic step(input bit req, input logic [27:0] pat);
    logic [3:0] an_exp;
    logic [6:0] seg_exp;
    bit         owner_pre;
    int         idx;
    @(negedge clk);
    msg_req = req;
    msg_seg = req ? pat : 28'($urandom);
    idx = (c / ScanDiv) % 4;
    owner_pre = m_owner;
    if (m_owner) begin
      an_exp  = ~(4'b0001 << idx);
      seg_exp = m_pat[idx*7 +: 7];
    end else if (!ent_val || !ent_mask[idx]) begin
      an_exp  = 4'hF;
      seg_exp = 7'h7F;
    end else begin
      an_exp  = ~(4'b0001 << idx);
      seg_exp = Glyph[ent_data[idx*4 +: 4]];
    end
    @(posedge clk);
    m_done = 1'b0;
    if (req) begin
      m_pat = pat;
      if (!m_busy) begin
        m_busy  = 1'b1;
        m_start = next_bnd(c);
        m_end   = m_start + FrameLen * MsgFrames;
      end else if (c > m_start) begin
        m_end = next_bnd(c) + FrameLen * (MsgFrames - 1);
      end
    end
    if (m_busy && c == m_end) begin
      m_busy = 1'b0;
      m_done = 1'b1;
    end
    m_owner = m_busy && (c >= m_start) && (c < m_end);
    c++;
    #1;
    msg_req = 1'b0;
    if (msg_done === 1'b1) done_seen++;
    check_eq("AN", 32'(AN), 32'(an_exp));
    if (an_exp != 4'hF || (!owner_pre && !ent_val)) check_eq("seven_out", 32'(seven_out), 32'(seg_exp));
    check_eq("owner", 32'(owner), 32'(m_owner));
    check_eq("msg_busy", 32'(msg_busy), 32'(m_busy));
    check_eq("msg_done", 32'(msg_done), 32'(m_done));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_AN"}, 32'(AN), 32'hF);
    check_eq({tag, "_seg"}, 32'(seven_out), 32'h7F);
    check_eq({tag, "_owner"}, 32'(owner), 32'h0);
    check_eq({tag, "_busy"}, 32'(msg_busy), 32'h0);
    check_eq({tag, "_done"}, 32'(msg_done), 32'h0);
  endtask

  task automatic model_reset();
    c       = 0;
    m_busy  = 1'b0;
    m_owner = 1'b0;
    m_done  = 1'b0;
    m_start = 0;
    m_end   = 0;
  endtask

  initial begin
    int unsigned d0;
    logic [27:0] p;

    // Reset with entry invalid
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst_hold");
    rst = 1'b0;
    model_reset();
    repeat (20) step(1'b0, '0);

    // Entry display, all digits, then masked
    ent_val = 1'b1; ent_data = 16'h1234; ent_mask = 4'hF;
    repeat (32) step(1'b0, '0);
    ent_mask = 4'b0011;
    repeat (32) step(1'b0, '0);
    ent_mask = 4'hF;

    // Message requested while digit 1 is lit
    for (int i = 0; i < 16 && ((c / ScanDiv) % 4) != 1; i++) step(1'b0, '0);
    d0 = done_seen;
    step(1'b1, {4{7'h40}});
    repeat (80) step(1'b0, '0);
    check_eq("done_once", done_seen - d0, 1);

    // Retrigger in the second SHOW frame
    d0 = done_seen;
    step(1'b1, 28'(pick_pattern()));
    for (int i = 0; i < 100 && c != m_start + FrameLen + 6; i++) step(1'b0, '0);
    step(1'b1, 28'(pick_pattern()));
    repeat (90) step(1'b0, '0);
    check_eq("retrig_done_once", done_seen - d0, 1);

    // Request on the WAIT-exit boundary, then on the final SHOW boundary
    d0 = done_seen;
    ent_data = 16'hABCD;
    step(1'b1, 28'(pick_pattern()));
    for (int i = 0; i < 40 && c != m_start; i++) step(1'b0, '0);
    step(1'b1, 28'(pick_pattern()));
    for (int i = 0; i < 100 && c != m_end; i++) step(1'b0, '0);
    step(1'b1, 28'(pick_pattern()));
    repeat (80) step(1'b0, '0);
    check_eq("edge_done_once", done_seen - d0, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        ent_val  = ($urandom_range(0, 5) != 0);
        ent_data = 16'($urandom);
        ent_mask = 4'($urandom);
      end
      p = 28'(pick_pattern());
      step($urandom_range(0, 29) == 0, p);
    end

    // Asynchronous reset while a message is showing
    ent_val = 1'b1; ent_mask = 4'hF;
    for (int i = 0; i < 100 && m_busy; i++) step(1'b0, '0);
    d0 = done_seen;
    step(1'b1, 28'(pick_pattern()));
    repeat (25) step(1'b0, '0);
    check_eq("show_before_rst", 32'(owner), 32'h1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(posedge clk);
    #1 check_reset_outputs("rst_mid_hold");
    if (msg_done === 1'b1) done_seen++;
    rst = 1'b0;
    model_reset();
    repeat (40) step(1'b0, '0);
    check_eq("no_done_after_rst", done_seen - d0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ssd_display_arbiter.md
Name: ssd_display_arbiter

Overview:
- Time-multiplexed 4-digit seven-segment scan controller that shares the display between two requesters.
- Entry source: the code-entry datapath, which shows four hex nibbles continuously.
- Message source: the lock state machine, which shows a raw segment pattern (e.g. OPEN/FAIL) for a fixed number of scan frames.
- Sits between the ASM and the board AN/seven_out pins; clocked by the fast divided clock.

Parameters:
- SCAN_DIV, 5000, clk cycles each digit is lit (min 2).
- MSG_FRAMES, 200, full 4-digit frames a message owns the display (min 1).

Ports:
- clk  in  1  scan clock
- rst  in  1  reset, asynchronous, active-high
- ent_val  in  1  entry source has valid data; 0 blanks the display while entry owns it
- ent_data  in  16  entry nibbles; digit i = ent_data[4i+3:4i], digit 0 rightmost
- ent_mask  in  4  per-digit enable for entry; 1 = show
- msg_req  in  1  one-cycle pulse requesting message display
- msg_seg  in  28  message pattern, active-low {g,f,e,d,c,b,a}; digit i = msg_seg[7i+6:7i]; latched on msg_req
- msg_busy  out  1  request pending or message showing
- msg_done  out  1  one-cycle pulse when the display returns to entry
- owner  out  1  0 = entry, 1 = message
- AN  out  4  digit anodes, active-low, one-hot-low
- seven_out  out  7  segments, active-low {g,f,e,d,c,b,a}

Behaviour:
- Reset values:
  - tick=0, idx=0, state=ENTRY, frame count=0.
  - AN=4'b1111, seven_out=7'h7F, msg_busy=0, msg_done=0, owner=0.
- Scan:
  - tick counts 0..SCAN_DIV-1 and wraps.
  - On wrap (terminal tick), idx advances 0→1→2→3→0.
  - Frame boundary = terminal tick with idx==3.
- Outputs: AN and seven_out are registered and update one cycle after idx changes.
- AN for the selected digit:
  - Normally ~(4'b0001<<idx).
  - Forced to 4'b1111 when owner=0 and either ent_val=0 or ent_mask[idx]=0.
- Segments:
  - owner=0: hex decode of the nibble (0-F, standard glyphs).
  - owner=1: latched msg_seg slice.
- States:
  - ENTRY: owner=0. msg_req latches msg_seg, sets msg_busy, and moves to WAIT.
  - WAIT: owner=0. Waits for the next frame boundary, then moves to SHOW with frame count cleared. Message ownership therefore always starts at digit 0.
    - msg_req in WAIT re-latches the pattern and stays in WAIT.
  - SHOW: owner=1. Frame count increments at each frame boundary. At the boundary that completes MSG_FRAMES frames:
    - move to ENTRY;
    - clear msg_busy;
    - pulse msg_done for exactly one cycle.
    - msg_req in SHOW (retrigger) re-latches the pattern, clears frame count, and stays in SHOW.
- Simultaneous events:
  - msg_req on the same cycle as the final frame boundary is treated as a retrigger: stay in SHOW, no msg_done.
  - msg_req on the same cycle as the WAIT-exit boundary: latch the new pattern and enter SHOW.
- Entry inputs are sampled live each cycle; no handshake.
- Reset mid-operation: all state returns to reset values immediately; no msg_done is emitted.

Optional Feature:
- Macro: SSD_MSG_BLINK_EN.
- Defined: in SHOW, AN is forced to 4'b1111 on frames where frame count bit 2 is 1, so the message blinks every 4 frames.
- Undefined: the message is steady.
- Entry display is unaffected either way.

Decomposition:
- Shared package ssd_pkg holds:
  - state encodings ENTRY/WAIT/SHOW;
  - SEG_BLANK=7'h7F and AN_OFF=4'hF;
  - hex glyph constants.
- One natural sub-module, hex_to_seg: combinational 4-bit to 7-bit active-low decoder, reusable by other display paths.

Test Plan (all scenarios use SCAN_DIV=4, MSG_FRAMES=3):
- Reset asserted, ent_val=0 → AN=1111, seven_out=7F throughout reset and after release.
- ent_val=1, ent_data=16'h1234, ent_mask=1111 → AN steps 1110/1101/1011/0111, 4 clocks each, with seven_out 19/30/24/79 (4,3,2,1).
- ent_mask=0011, data 16'h1234 → AN shows only 1110 and 1101; digits 2,3 stay 1111 during their slots.
- msg_req (msg_seg=all 7'h40) while idx=1:
  - msg_busy=1 next cycle; owner stays 0 until the idx3 terminal tick;
  - owner=1 for 48 clocks, seven_out=40;
  - then msg_done pulses once, owner=0, msg_busy=0.
- Retrigger msg_req in SHOW frame 2 → frame count restarts; owner stays 1 for 3 further frames; one msg_done total.
- rst pulse during SHOW → owner=0, msg_busy=0, AN=1111 asynchronously; no msg_done.
